// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline boundary register with valid/ready, stall, flush-to-bubble and optional skid entry
module pipe_stage_reg #(
  parameter int unsigned       DATA_W = 32,
  parameter bit                SKID   = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_q, vld, acc, emit, inc;
  assign vld       = state_q != EMPTY;
  assign out_valid = enable & vld;
  assign out_data  = out_valid ? main_q : BUBBLE;
  // rdy_q also keeps in_ready low until the first edge after reset
  assign in_ready  = enable & rdy_q & (SKID ? 1'b1 : (!vld | out_ready));
  assign acc       = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign inc       = enable & vld & !out_ready & !flush & ~&cnt_q;
  assign cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, inc};
  assign stall_cnt = cnt_q;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) state_d = EMPTY;
    else case (state_q)
      EMPTY: if (acc) begin
        state_d = ONE;
        main_d  = in_data;
      end
      ONE: if (acc && emit) main_d = in_data;
      else if (acc) begin
        state_d = FULL;
        skid_d  = in_data;
      end else if (emit) state_d = EMPTY;
      FULL: if (emit) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
      rdy_q   <= state_d != FULL;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: three configurations driven in parallel and checked against a queue model
module tb_pipe_stage_reg;
  logic        clk = 1'b0, rst = 1'b1;
  logic        enable = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [31:0] od0, od1, od2;
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;
  int          n_tot = 0, n_bad = 0;
  logic [31:0] md[3][2];
  int          mn[3], mc[3];
  bit          mr[3];
  localparam logic [31:0] BUB [3] = '{32'h0000_0013, 32'hFFFF_FFFF, 32'h0};
  localparam int          CMAX[3] = '{65535, 65535, 15};

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .SKID(1'b1), .BUBBLE(32'h0000_0013), .CNT_W(16)) dut0 (
    .CLK(clk), .RST(rst), .enable(enable), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .stall_cnt(sc0));
  pipe_stage_reg #(.DATA_W(32), .SKID(1'b0), .BUBBLE(32'hFFFF_FFFF), .CNT_W(16)) dut1 (
    .CLK(clk), .RST(rst), .enable(enable), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .stall_cnt(sc1));
  pipe_stage_reg #(.DATA_W(32), .SKID(1'b1), .CNT_W(4)) dut2 (
    .CLK(clk), .RST(rst), .enable(enable), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .stall_cnt(sc2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic bit exp_ov(int i);
    return enable && mn[i] > 0;
  endfunction
  // skid variants hold two entries; the pass-through variant frees its slot when downstream takes it
  function automatic bit exp_ir(int i);
    return enable && mr[i] && (i == 1 ? (mn[i] == 0 || out_ready) : mn[i] < 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mn[i] = 0;
      mc[i] = 0;
      mr[i] = 1'b0;
    end
  endtask

  task automatic expect_now();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] od, sc;
      logic        ov, ir;
      ov = i == 0 ? ov0 : i == 1 ? ov1 : ov2;
      ir = i == 0 ? ir0 : i == 1 ? ir1 : ir2;
      od = i == 0 ? od0 : i == 1 ? od1 : od2;
      sc = i == 0 ? 32'(sc0) : i == 1 ? 32'(sc1) : 32'(sc2);
      chk($sformatf("out_valid%0d", i), 32'(ov), 32'(exp_ov(i)));
      chk($sformatf("in_ready%0d", i), 32'(ir), 32'(exp_ir(i)));
      chk($sformatf("out_data%0d", i), od, exp_ov(i) ? md[i][0] : BUB[i]);
      chk($sformatf("stall_cnt%0d", i), sc, 32'(mc[i]));
    end
  endtask

  task automatic cycle(input bit en, input bit fl, input bit iv, input bit orr, input logic [31:0] d);
    bit acc[3], emi[3], stl[3];
    enable = en; flush = fl; in_valid = iv; out_ready = orr; in_data = d;
    #1;
    expect_now();
    for (int i = 0; i < 3; i++) begin
      acc[i] = iv && exp_ir(i);
      emi[i] = exp_ov(i) && orr;
      stl[i] = exp_ov(i) && !orr && !fl;
    end
    @(posedge clk);
    if (!rst) for (int i = 0; i < 3; i++) begin
      mr[i] = 1'b1;
      if (fl) mn[i] = 0;
      else begin
        if (emi[i]) begin
          md[i][0] = md[i][1];
          mn[i]--;
        end
        if (acc[i]) begin
          md[i][mn[i]] = d;
          mn[i]++;
        end
      end
      if (stl[i] && mc[i] < CMAX[i]) mc[i]++;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    cycle(1, 0, 1, 1, 32'h99);
    cycle(1, 0, 1, 1, 32'h98);
    rst = 1'b0;
    cycle(1, 0, 0, 1, 32'h0);
    for (int k = 1; k <= 8; k++) cycle(1, 0, 1, 1, 32'(k));
    repeat (2) cycle(1, 0, 0, 1, 32'h0);
    cycle(1, 0, 1, 1, 32'hA);
    cycle(1, 0, 1, 0, 32'hB);
    cycle(1, 0, 1, 0, 32'hC);
    cycle(1, 0, 1, 0, 32'hC);
    cycle(1, 0, 1, 1, 32'hC);
    repeat (4) cycle(1, 0, 0, 1, 32'h0);
    cycle(1, 0, 1, 0, 32'h11);
    cycle(1, 0, 1, 0, 32'h22);
    cycle(1, 1, 1, 0, 32'hDEAD);
    repeat (2) cycle(1, 0, 0, 1, 32'h0);
    cycle(1, 0, 1, 0, 32'h55);
    repeat (2) cycle(0, 0, 1, 1, 32'h77);
    repeat (2) cycle(1, 0, 0, 1, 32'h0);
    cycle(1, 0, 1, 0, 32'h66);
    cycle(0, 1, 0, 0, 32'h0);
    cycle(1, 0, 0, 1, 32'h0);
    cycle(1, 0, 1, 0, 32'h77);
    repeat (20) cycle(1, 0, 0, 0, 32'h0);
    repeat (3) cycle(1, 0, 0, 1, 32'h0);
    repeat (400) cycle($urandom_range(9) != 0, $urandom_range(19) == 0,
                       $urandom_range(4) < 3, $urandom_range(4) < 3, $urandom);
    for (int k = 0; k < 3; k++) cycle(1, 0, 1, 0, 32'h100 + 32'(k));
    #2 rst = 1'b1;
    #1 model_reset();
    expect_now();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) cycle(1, 0, 1, 1, 32'(k));
    repeat (2) cycle(1, 0, 0, 1, 32'h0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
